// File: rtl/cubic_avg.sv
// cubic_avg: block averager for the cubic evaluator's output stream.
// Each group of 2^LOG2N signed fix<10,6> samples becomes one result: the mean,
// rounded half toward +inf, together with the minimum and maximum of the group.
// Both the input and the output use a valid/ready handshake. While a result is
// waiting downstream, only the sample that would complete the next block is
// stalled; earlier samples of that block are still accepted.
module cubic_avg #(
    parameter int LOG2N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [9:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic signed [9:0] out_data,
    output logic signed [9:0] out_min,
    output logic signed [9:0] out_max
);

    // The accumulator holds at most N-1 samples, so 10+LOG2N bits never overflow.
    // The rounding sum uses one extra bit of headroom so that adding the
    // half-LSB constant to a full-scale block cannot wrap.
    localparam int AW = 10 + LOG2N;

    localparam logic [LOG2N-1:0]   CNT_LAST = '1;
    localparam logic [LOG2N-1:0]   CNT_ONE  = LOG2N'(1);
    localparam logic signed [AW:0] HALF     = (AW+1)'(1 << (LOG2N-1));
    localparam logic signed [9:0]  MIN_INIT = 10'sh1FF;
    localparam logic signed [9:0]  MAX_INIT = 10'sh200;

    logic signed [AW-1:0] acc;
    logic [LOG2N-1:0]     cnt;
    logic signed [9:0]    run_min;
    logic signed [9:0]    run_max;

    logic                 last;
    logic                 accept;
    logic                 complete;
    logic signed [AW:0]   sum_ext;
    logic signed [AW:0]   rounded;
    logic signed [9:0]    mean;
    logic signed [9:0]    next_min;
    logic signed [9:0]    next_max;

    // Handshake qualification, the running sum including the current sample,
    // and the rounded mean of a completed block.
    always_comb begin
        last     = (cnt == CNT_LAST);
        // A pending result blocks only the block-completing sample. A same-cycle
        // out_ready frees the slot, so consume and reload happen on one edge.
        in_ready = !rst && !(out_valid && !out_ready && last);
        accept   = in_valid && in_ready;
        complete = accept && last;
        sum_ext  = (AW+1)'(acc) + (AW+1)'(in_data);
        rounded  = sum_ext + HALF;
        // An arithmetic shift floors the result, so adding half an LSB first
        // rounds half toward +inf. The mean of 10-bit samples always fits in
        // 10 bits, so truncation here is exact.
        mean     = 10'(rounded >>> LOG2N);
        next_min = (in_data < run_min) ? in_data : run_min;
        next_max = (in_data > run_max) ? in_data : run_max;
    end

    // Running block state: sum, sample count, and extremes. All of it returns
    // to the empty-block values when a block completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            run_min <= MIN_INIT;
            run_max <= MAX_INIT;
        end else if (accept) begin
            if (last) begin
                acc     <= '0;
                cnt     <= '0;
                run_min <= MIN_INIT;
                run_max <= MAX_INIT;
            end else begin
                acc     <= sum_ext[AW-1:0];
                cnt     <= cnt + CNT_ONE;
                run_min <= next_min;
                run_max <= next_max;
            end
        end
    end

    // Result registers: load when a block completes, and hold while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_min  <= '0;
            out_max  <= '0;
        end else if (complete) begin
            out_data <= mean;
            out_min  <= next_min;
            out_max  <= next_max;
        end
    end

    // out_valid is set when a block completes, even when the previous result
    // is consumed on the same edge. Otherwise it clears when the result is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (complete) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cubic_avg.sv
// tb_cubic_avg: directed vectors with hand-computed results for cubic_avg, LOG2N=2.
module tb_cubic_avg;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [9:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [9:0] out_data;
    logic signed [9:0] out_min;
    logic signed [9:0] out_max;

    int total;
    int bad;

    cubic_avg #(.LOG2N(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_min   (out_min),
        .out_max   (out_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [15:0] got,
                       input logic signed [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and keep in_valid high until an edge accepts it.
    // in_valid stays high afterwards; the caller drops it if needed.
    task automatic send(input logic signed [9:0] s);
        logic taken;
        int   n;
        taken = 1'b0;
        n     = 0;
        in_valid = 1'b1;
        in_data  = s;
        while (!taken && n < 20) begin
            #1;
            taken = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!taken) chk("accept_timeout", 16'sd0, 16'sd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 10'sd300;
    endtask

    task automatic check_result(input string tag, input int d, input int mn, input int mx);
        chk({tag, "_valid"}, 16'(out_valid), 16'sd1);
        chk({tag, "_data"},  16'(out_data),  16'(d));
        chk({tag, "_min"},   16'(out_min),   16'(mn));
        chk({tag, "_max"},   16'(out_max),   16'(mx));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_in_ready",  16'(in_ready),  16'sd0);
        chk("rst_out_valid", 16'(out_valid), 16'sd0);
        chk("rst_out_data",  16'(out_data),  16'sd0);
        chk("rst_out_min",   16'(out_min),   16'sd0);
        chk("rst_out_max",   16'(out_max),   16'sd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 16'(in_ready), 16'sd1);

        // Rounding up: 224 + 2 = 226, >>> 2 = 56
        send(10'sd64);
        send(10'sd64);
        send(10'sd64);
        chk("ru_not_early", 16'(out_valid), 16'sd0);
        send(10'sd32);
        idle();
        check_result("ru", 56, 32, 64);
        step();
        chk("ru_consumed", 16'(out_valid), 16'sd0);

        // Negative rounding: -5 + 2 = -3 -> -1; -9 + 2 = -7 -> -2
        send(-10'sd1);
        send(-10'sd1);
        send(-10'sd1);
        send(-10'sd2);
        idle();
        check_result("neg1", -1, -2, -1);
        send(-10'sd2);
        send(-10'sd2);
        send(-10'sd2);
        send(-10'sd3);
        idle();
        check_result("neg2", -2, -3, -2);

        // Full scale: 2044 + 2 -> 511; -2048 + 2 -> -512
        for (int i = 0; i < 4; i++) send(10'sd511);
        idle();
        check_result("fs_pos", 511, 511, 511);
        for (int i = 0; i < 4; i++) send(-10'sd512);
        idle();
        check_result("fs_neg", -512, -512, -512);
        step();

        // Backpressure: blocks 1,2,3,4 -> 3 and 5,6,7,8 -> 7
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) send(10'(i));
        check_result("bp_first", 3, 1, 4);
        in_data = 10'sd8;
        #1;
        chk("bp_stall", 16'(in_ready), 16'sd0);
        for (int i = 0; i < 3; i++) step();
        chk("bp_stall_hold", 16'(in_ready), 16'sd0);
        check_result("bp_held", 3, 1, 4);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 16'(in_ready), 16'sd1);
        step();
        out_ready = 1'b0;
        idle();
        check_result("bp_second", 7, 5, 8);
        step();
        chk("bp_second_held", 16'(out_data), 16'sd7);
        out_ready = 1'b1;
        step();
        chk("bp_drained", 16'(out_valid), 16'sd0);

        // Reset mid-block discards the two samples of 100
        send(10'sd100);
        send(10'sd100);
        idle();
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 16'(in_ready), 16'sd0);
        step();
        chk("mid_rst_out_valid", 16'(out_valid), 16'sd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) send(10'sd8);
        chk("mid_rst_no_early", 16'(out_valid), 16'sd0);
        send(10'sd8);
        idle();
        check_result("mid_rst", 8, 8, 8);
        step();

        // Idle gaps between samples must not advance the count
        for (int i = 0; i < 4; i++) begin
            idle();
            repeat ($urandom_range(0, 3)) step();
            if (i == 3) chk("gap_no_early", 16'(out_valid), 16'sd0);
            send(10'sd10);
        end
        idle();
        check_result("gap", 10, 10, 10);
        step();
        chk("gap_single", 16'(out_valid), 16'sd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cubic_avg.md
Name: cubic_avg

Overview:
- Downstream consumer of the cubic evaluator.
- Takes the stream of f(x) results, signed fix<10,6>, over a valid/ready handshake.
- Reduces each block of 2^LOG2N consecutive samples to one rounded mean, plus the block minimum and maximum, all in fix<10,6>.
- Backpressure is honoured on both sides. Results feed the next block in the processing chain.

Parameters:
- LOG2N, 2, log2 of the block length N = 2^LOG2N. Legal range 1..6.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_data holds a sample
- in_ready  output  1  block accepts a sample this cycle
- in_data  input  10  sample, signed fix<10,6>
- out_valid  output  1  result registers hold an unconsumed block result
- out_ready  input  1  downstream accepts the result this cycle
- out_data  output  10  rounded block mean, signed fix<10,6>
- out_min  output  10  block minimum, signed fix<10,6>
- out_max  output  10  block maximum, signed fix<10,6>

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - While rst is high at a clock edge, all state clears: acc=0, cnt=0, running min=+511, running max=-512, out_valid=0, out_data/out_min/out_max=0.
  - in_ready is forced to 0 while rst=1.
  - Reset mid-block discards the partial block and any pending result.
- Accept and accumulate:
  - Accept = in_valid && in_ready.
  - On accept, acc += sign-extended in_data. acc is signed, 10+LOG2N bits, and never overflows.
  - On accept, cnt increments modulo N; running min/max update with signed compare.
- Block completion, when accepting with cnt==N-1:
  - out_data <= (acc + in_data + 2^(LOG2N-1)) >>> LOG2N. This is round-half-toward-+inf of the mean.
  - The result always lies in [-512,511], so there is no saturation logic.
  - out_min/out_max load the final running values, including this sample.
  - out_valid <= 1.
  - acc, cnt, min and max return to their reset values in the same edge.
- Latency: out_valid rises exactly 1 cycle after the final sample's accept edge.
- Output handshake:
  - out_valid clears on the edge where out_valid && out_ready, unless a new block completes on the same edge, in which case it stays 1 with new data.
  - out_data/out_min/out_max are held stable while out_valid && !out_ready.
- in_ready = !rst && !(out_valid && !out_ready && cnt==N-1).
  - Samples 0..N-2 of the next block are accepted while a result is pending.
  - Only the block-completing sample stalls.
  - In-stall, in_ready follows out_ready combinationally in the same cycle, so a pending result is consumed and the next one is loaded on the same edge with no bubble.
- in_data is ignored when no accept occurs.
- An incoming 0 is an ordinary sample; the upstream overflow-zero output gets no special handling.

Test Plan (LOG2N=2, raw integer codes, 1.0 = 64):
- Rounding up: samples 64,64,64,32, out_ready=1 -> one cycle after the 4th accept, out_valid=1, out_data=56 (0x038), out_min=32, out_max=64.
- Negative rounding: samples -1,-1,-1,-2 -> out_data=-1 (0x3FF), out_min=-2, out_max=-1. Then samples -2,-2,-2,-3 -> sum -9, out_data=-2.
- Full scale: four samples of 511 -> out_data=511. Four samples of -512 -> out_data=-512. No wrap.
- Backpressure:
  - out_ready=0, in_valid=1 continuously with 8 samples.
  - First result appears; samples 5-7 are accepted; in_ready=0 on sample 8 and stays 0 with the result held stable.
  - Raise out_ready for 1 cycle -> sample 8 is accepted on that edge; next cycle out_valid=1 with the second block's result.
- Reset mid-block: accept 2 samples of 100, assert rst 1 cycle, then samples 8,8,8,8 -> out_data=8. out_valid stays 0 throughout reset.
- Idle gaps: in_valid toggled with random gaps between 4 samples of 10 -> a single result of 10. cnt is unaffected by non-accept cycles.
